// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   tx_state_e   - transmitter FSM states
//   FIFO_DEPTH   - character buffer depth when the FIFO build is selected
//   baud_divisor - clocks per line bit (truncated)
//   cnt_width    - baud counter width for a given divisor (at least 1 bit)
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = FIFO_PTR_W + 1;

  function automatic int baud_divisor(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int cnt_width(input int divisor);
    return (divisor > 1) ? $clog2(divisor) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO_DEPTH-entry character buffer with wrap-around pointers.
//   S_AXI_ACLK / S_AXI_ARESET - clock, async active-high reset
//   push, push_data           - write (ignored when full)
//   pop, pop_data             - read (ignored when empty); pop_data is show-ahead
//   count                     - registered occupancy, 0..FIFO_DEPTH
// Push and pop in the same cycle leave count unchanged.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic [DATA_W-1:0]     pop_data,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [DATA_W-1:0]     mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign do_push  = push && (count != FIFO_CNT_W'(FIFO_DEPTH));
  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the count alone defines what is valid.
  always_ff @(posedge S_AXI_ACLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_controller.sv
// uart_tx_controller: buffered UART transmitter (start, C_DATA_BITS LSB first,
// optional parity, one stop bit).
//   S_AXI_ACLK, S_AXI_ARESET (async, active-high)
//   TX_DATA/TX_VALID/TX_READY - character write handshake
//   TX       - registered serial line, idle high
//   TX_BUSY  - FSM outside IDLE
//   TX_EMPTY - no characters buffered
//   TX_DONE_IRQ - one-cycle pulse as the final stop bit leaves the line
// Build option: UART_TX_FIFO_EN selects a 16-entry FIFO buffer; otherwise a
// single holding register is used.
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int C_S_AXI_ACLK_FREQ_HZ = 100_000_000,
  parameter int C_BAUDRATE           = 9600,
  parameter int C_DATA_BITS          = 8,
  parameter int C_USE_PARITY         = 0,
  parameter int C_ODD_PARITY         = 0
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESET,
  input  logic [C_DATA_BITS-1:0] TX_DATA,
  input  logic                   TX_VALID,
  output logic                   TX_READY,
  output logic                   TX,
  output logic                   TX_BUSY,
  output logic                   TX_EMPTY,
  output logic                   TX_DONE_IRQ
);

  localparam int             DIVISOR = baud_divisor(C_S_AXI_ACLK_FREQ_HZ, C_BAUDRATE);
  localparam int             CNT_W   = cnt_width(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVISOR - 1);
  localparam logic           ODD_BIT = (C_ODD_PARITY != 0);

  tx_state_e              state, state_nxt;
  logic [CNT_W-1:0]       cnt_q;
  logic [2:0]             bit_q;
  logic [C_DATA_BITS-1:0] sh_q;
  logic                   par_q, tx_q, done_q, irq_q;
  logic                   bit_end, push, pop, buf_empty;
  logic [C_DATA_BITS-1:0] buf_data;

  assign push = TX_VALID && TX_READY;

`ifdef UART_TX_FIFO_EN
  logic [FIFO_CNT_W-1:0] fifo_count;

  uart_tx_fifo #(.DATA_W(C_DATA_BITS)) u_fifo (
    .S_AXI_ACLK   (S_AXI_ACLK),
    .S_AXI_ARESET (S_AXI_ARESET),
    .push         (push),
    .push_data    (TX_DATA),
    .pop          (pop),
    .pop_data     (buf_data),
    .count        (fifo_count)
  );

  assign TX_READY  = (fifo_count != FIFO_CNT_W'(FIFO_DEPTH));
  assign buf_empty = (fifo_count == '0);
`else
  // Single holding register: refills while the previous character is on the line.
  logic                   hold_vld;
  logic [C_DATA_BITS-1:0] hold_data;

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else if (push) begin
      hold_vld  <= 1'b1;
      hold_data <= TX_DATA;
    end else if (pop) begin
      hold_vld  <= 1'b0;
    end
  end

  assign TX_READY  = !hold_vld;
  assign buf_empty = !hold_vld;
  assign buf_data  = hold_data;
`endif

  assign bit_end = (cnt_q == '0);

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:   if (!buf_empty) begin
                pop       = 1'b1;
                state_nxt = START;
              end
      START:  if (bit_end) state_nxt = DATA;
      DATA:   if (bit_end && (bit_q == 3'(C_DATA_BITS - 1))) begin
                if (C_USE_PARITY != 0) state_nxt = PARITY;
                else                   state_nxt = STOP;
              end
      PARITY: if (bit_end) state_nxt = STOP;
      STOP:   if (bit_end) begin
                // Back-to-back frames: reload straight into START, no idle bit.
                if (!buf_empty) begin
                  pop       = 1'b1;
                  state_nxt = START;
                end else begin
                  state_nxt = IDLE;
                end
              end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      cnt_q <= '0;
      bit_q <= '0;
      sh_q  <= '0;
      par_q <= 1'b0;
    end else if (pop) begin
      sh_q  <= buf_data;
      par_q <= (^buf_data) ^ ODD_BIT;
      cnt_q <= CNT_MAX;
      bit_q <= '0;
    end else if (state_nxt == IDLE) begin
      cnt_q <= '0;
      bit_q <= '0;
    end else if (bit_end) begin
      cnt_q <= CNT_MAX;
      if (state == DATA) begin
        sh_q  <= sh_q >> 1;
        bit_q <= bit_q + 1'b1;
      end
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Line and IRQ are registered one cycle behind the FSM, so the pulse lines
  // up with the end of the stop bit as seen on TX.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      tx_q   <= 1'b1;
      done_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      case (state)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= sh_q[0];
        PARITY:  tx_q <= par_q;
        default: tx_q <= 1'b1;
      endcase
      done_q <= (state == STOP) && (state_nxt == IDLE);
      irq_q  <= done_q;
    end
  end

  assign TX          = tx_q;
  assign TX_BUSY     = (state != IDLE);
  assign TX_EMPTY    = buf_empty;
  assign TX_DONE_IRQ = irq_q;

endmodule
